// File: rtl/incrementer.sv
// incrementer: registered in+STEP stage with ripple or Kogge-Stone carry; wraps by default.
// Define INCREMENTER_SATURATE_EN to clamp out to all-ones on overflow (carry still set).
module incrementer #(
    parameter int WIDTH  = 30,
    parameter int STEP   = 1,
    parameter int PREFIX = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             carry
);
    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(STEP);
    logic [WIDTH-1:0] g, p, sum, out_d, out_q;
    logic [WIDTH:0]   c;
    logic             carry_d, carry_q;
    assign g    = in & STEP_C;
    assign p    = in ^ STEP_C;
    assign c[0] = 1'b0;
    generate
        if (PREFIX != 0) begin : g_ks
            localparam int L = $clog2(WIDTH);
            logic [L:0][WIDTH-1:0] gk, pk;
            assign gk[0] = g;
            assign pk[0] = p;
            for (genvar k = 1; k <= L; k++) begin : g_lvl
                for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                    if (i >= (1 << (k - 1))) begin : g_op
                        assign gk[k][i] = gk[k-1][i] | (pk[k-1][i] & gk[k-1][i-(1<<(k-1))]);
                        assign pk[k][i] = pk[k-1][i] & pk[k-1][i-(1<<(k-1))];
                    end else begin : g_pass
                        assign gk[k][i] = gk[k-1][i];
                        assign pk[k][i] = pk[k-1][i];
                    end
                end
            end
            // Group terms span down to bit 0, so the carry-in folds in at the last level.
            for (genvar i = 0; i < WIDTH; i++) begin : g_c
                assign c[i+1] = gk[L][i] | (pk[L][i] & c[0]);
            end
        end else begin : g_rc
            for (genvar i = 0; i < WIDTH; i++) begin : g_c
                assign c[i+1] = g[i] | (p[i] & c[i]);
            end
        end
    endgenerate
    assign sum     = p ^ c[WIDTH-1:0];
    assign carry_d = c[WIDTH];
`ifdef INCREMENTER_SATURATE_EN
    assign out_d = carry_d ? '1 : sum;
`else
    assign out_d = sum;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else if (enable) begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end
    assign out   = out_q;
    assign carry = carry_q;
endmodule

// File: tb/tb_incrementer.sv
// tb_incrementer: directed and random checks of ripple and Kogge-Stone builds side by side.
module tb_incrementer;
    localparam int W = 30;
    logic         clk = 1'b0;
    logic         reset, enable;
    logic [W-1:0] in_v, out0, out1;
    logic         c0, c1;
    logic [W:0]   wrap_exp;
    int           checks = 0;
    int           errors = 0;
    always #5 clk = ~clk;
    incrementer #(.WIDTH(W), .STEP(1), .PREFIX(0)) u_rc (
        .clk(clk), .reset(reset), .enable(enable), .in(in_v), .out(out0), .carry(c0)
    );
    incrementer #(.WIDTH(W), .STEP(1), .PREFIX(1)) u_ks (
        .clk(clk), .reset(reset), .enable(enable), .in(in_v), .out(out1), .carry(c1)
    );
    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic both(input string tag, input logic [W:0] exp);
        chk({tag, "_rc"}, {c0, out0}, exp);
        chk({tag, "_ks"}, {c1, out1}, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [W:0] model(input logic [W-1:0] a);
        logic [W:0] s;
        s = {1'b0, a} + 31'd1;
`ifdef INCREMENTER_SATURATE_EN
        if (s[W]) s[W-1:0] = '1;
`endif
        return s;
    endfunction
    initial begin
`ifdef INCREMENTER_SATURATE_EN
        wrap_exp = {1'b1, 30'h3FFFFFFF};
`else
        wrap_exp = {1'b1, 30'h0};
`endif
        reset = 1'b1; enable = 1'b0; in_v = '0;
        tick(); tick();
        both("reset", 31'd0);
        reset = 1'b0; enable = 1'b1; in_v = 30'd5;
        tick();
        both("inc5", 31'd6);
        tick();
        both("no_accum", 31'd6);
        enable = 1'b0; in_v = 30'd100;
        for (int n = 0; n < 10; n++) begin
            tick();
            both("hold", 31'd6);
        end
        enable = 1'b1; in_v = 30'h3FFFFFFF;
        tick();
        both("wrap", wrap_exp);
        enable = 1'b0; in_v = 30'd1;
        tick();
        both("wrap_hold", wrap_exp);
        enable = 1'b1; in_v = 30'h3FFFFFFE;
        tick();
        both("near_max", {1'b0, 30'h3FFFFFFF});
        in_v = 30'h1FFFFFFF;
        tick();
        both("long_carry", {1'b0, 30'h20000000});
        in_v = 30'd7; reset = 1'b1;
        tick();
        both("reset_prio", 31'd0);
        reset = 1'b0;
        tick();
        both("after_reset", 31'd8);
        enable = 1'b0; reset = 1'b1;
        tick();
        both("reset_idle", 31'd0);
        reset = 1'b0; enable = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            in_v = (n % 50 == 0) ? 30'h3FFFFFFF - W'(n % 3) : W'($urandom);
            tick();
            both("rand", model(in_v));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
